// File: rtl/store_merge_buffer_pkg.sv
// Shared store op codes, byte-enable constants and the alignment result record
// used by the store merge buffer and its alignment stage.
package store_merge_buffer_pkg;

    localparam logic [2:0] ST_W      = 3'b000;
    localparam logic [2:0] ST_H      = 3'b001;
    localparam logic [2:0] ST_B      = 3'b010;
    localparam logic [3:0] ST_BE_ALL = 4'b1111;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
        logic        misalign;
        logic        legal;
    } align_t;

endpackage

// File: rtl/store_merge_buffer_align.sv
// Combinational store alignment: places sw/sh/sb data on byte lanes, builds byte
// enables and flags misaligned accesses and non-store op codes.
module store_merge_buffer_align
    import store_merge_buffer_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  op_i,
    output align_t      align_o
);

    always_comb begin
        // NOTE: every field gets a default first so no path through the case infers a latch.
        align_o = '0;
        case (op_i)
            ST_W: begin
                align_o.legal    = 1'b1;
                align_o.misalign = (addr_i != 2'b00);
                align_o.data     = wdata_i;
                align_o.be       = ST_BE_ALL;
            end
            ST_H: begin
                align_o.legal    = 1'b1;
                align_o.misalign = addr_i[0];
                if (addr_i[1]) begin
                    align_o.data = {wdata_i[15:0], 16'h0000};
                    align_o.be   = 4'b1100;
                end else begin
                    align_o.data = {16'h0000, wdata_i[15:0]};
                    align_o.be   = 4'b0011;
                end
            end
            ST_B: begin
                align_o.legal = 1'b1;
                align_o.data  = {24'h000000, wdata_i[7:0]} << {addr_i, 3'b000};
                align_o.be    = 4'b0001 << addr_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_merge_buffer.sv
// Store queue between MEM stage and data bus: aligns stores, merges into the
// youngest entry on a word hit, drains in order and forwards bytes to loads.
module store_merge_buffer
    import store_merge_buffer_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4,
    parameter int COMBINE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_wdata,
    input  logic [2:0]        st_op,
    output logic              st_exc,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byteen,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [3:0]        ld_fwd_en,
    output logic [31:0]       ld_fwd_data,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WA_W-1:0]  waddr_q [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [3:0]       be_q    [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, youngest, fwd_idx;
    logic [CNT_W-1:0] count_q, count_d;

    align_t    al;
    logic      accept, pop, merge, push;
    logic [WA_W-1:0] st_word, ld_word;
    logic      ld_addr_unused;

    store_merge_buffer_align u_align (
        .addr_i  (st_addr[1:0]),
        .wdata_i (st_wdata),
        .op_i    (st_op),
        .align_o (al)
    );

    assign st_word        = st_addr[ADDR_W-1:2];
    assign ld_word        = ld_addr[ADDR_W-1:2];
    assign ld_addr_unused = ^ld_addr[1:0];
    assign youngest       = tail_q - PTR_W'(1);

    assign st_ready  = !reset && (count_q != FULL);
    assign st_exc    = st_valid && al.misalign;
    assign mem_valid = (count_q != '0);
    assign empty     = (count_q == '0);
    assign accept    = st_valid && st_ready && al.legal && !al.misalign;
    assign pop       = mem_valid && mem_ready;

    // A youngest entry leaving this cycle cannot absorb the store; it takes a fresh slot.
    assign merge = (COMBINE != 0) && accept && (count_q != '0) &&
                   (waddr_q[youngest] == st_word) && !(pop && count_q == CNT_W'(1));
    assign push  = accept && !merge;

    assign head_d  = head_q + PTR_W'(pop);
    assign tail_d  = tail_q + PTR_W'(push);
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    assign mem_addr   = {waddr_q[head_q], 2'b00};
    assign mem_wdata  = data_q[head_q];
    assign mem_byteen = be_q[head_q];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            // NOTE: entry storage is cleared on reset because mem_* must read as zero afterwards.
            for (int i = 0; i < DEPTH; i++) begin
                waddr_q[i] <= '0;
                data_q[i]  <= '0;
                be_q[i]    <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (pop) valid_q[head_q] <= 1'b0;
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                waddr_q[tail_q] <= st_word;
                data_q[tail_q]  <= al.data;
                be_q[tail_q]    <= al.be;
            end
            if (merge) begin
                for (int b = 0; b < 4; b++)
                    if (al.be[b]) data_q[youngest][8*b +: 8] <= al.data[8*b +: 8];
                be_q[youngest] <= be_q[youngest] | al.be;
            end
        end
    end

    // Scan oldest to youngest so the last matching entry (the youngest) wins each lane.
    always_comb begin
        ld_fwd_en   = '0;
        ld_fwd_data = '0;
        fwd_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PTR_W'(k);
            if (valid_q[fwd_idx] && (waddr_q[fwd_idx] == ld_word)) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_q[fwd_idx][b]) begin
                        ld_fwd_en[b]           = 1'b1;
                        ld_fwd_data[8*b +: 8]  = data_q[fwd_idx][8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_merge_buffer.sv
// Bench for store_merge_buffer: directed scenarios plus random traffic, all
// compared every cycle against a queue-of-stores reference model.
module tb_store_merge_buffer;

    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 4;
    localparam int COMBINE = 1;
    localparam logic [2:0] OP_W = 3'b000, OP_H = 3'b001, OP_B = 3'b010, OP_NONE = 3'b111;

    logic              clk;
    logic              reset;
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_wdata;
    logic [2:0]        st_op;
    logic              st_exc;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_byteen;
    logic [ADDR_W-1:0] ld_addr;
    logic [3:0]        ld_fwd_en;
    logic [31:0]       ld_fwd_data;
    logic              empty;

    store_merge_buffer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .COMBINE(COMBINE)) dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_wdata    (st_wdata),
        .st_op       (st_op),
        .st_exc      (st_exc),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_byteen  (mem_byteen),
        .ld_addr     (ld_addr),
        .ld_fwd_en   (ld_fwd_en),
        .ld_fwd_data (ld_fwd_data),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    int   vectors;
    int   miscompares;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference alignment: byte offset times eight gives the lane shift.
    task automatic ref_align(input logic [2:0] op, input logic [1:0] a, input logic [31:0] wd,
                             output logic legal, output logic exc,
                             output logic [31:0] d, output logic [3:0] be);
        int off;
        legal = 1'b0; exc = 1'b0; d = '0; be = '0;
        if (op == OP_W) begin
            legal = 1'b1; exc = (a != 2'd0); d = wd; be = 4'hF;
        end else if (op == OP_H) begin
            legal = 1'b1; exc = a[0]; off = a[1] ? 2 : 0;
            d = {16'h0, wd[15:0]} << (8 * off);
            be = 4'b0011 << off;
        end else if (op == OP_B) begin
            legal = 1'b1; off = int'(a);
            d = {24'h0, wd[7:0]} << (8 * off);
            be = 4'b0001 << off;
        end
    endtask

    task automatic step(input logic v, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] op, input logic mr, input logic [31:0] la,
                        input logic rst);
        logic legal, exc, rdy, acc, pop, mrg;
        logic [31:0] d, fd;
        logic [3:0] be, fe;
        ent_t e;
        st_valid = v; st_addr = addr; st_wdata = wd; st_op = op;
        mem_ready = mr; ld_addr = la; reset = rst;
        @(negedge clk);
        ref_align(op, addr[1:0], wd, legal, exc, d, be);
        rdy = !rst && (q.size() < DEPTH);
        check("st_ready", 32'(st_ready), 32'(rdy));
        check("st_exc", 32'(st_exc), 32'(v && legal && exc));
        check("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
        check("empty", 32'(empty), 32'(q.size() == 0));
        if (q.size() != 0) begin
            check("mem_addr", mem_addr, {q[0].waddr, 2'b00});
            check("mem_wdata", mem_wdata, q[0].data);
            check("mem_byteen", 32'(mem_byteen), 32'(q[0].be));
        end
        fe = '0; fd = '0;
        for (int i = 0; i < q.size(); i++)
            if (q[i].waddr == la[31:2])
                for (int b = 0; b < 4; b++)
                    if (q[i].be[b]) begin
                        fe[b] = 1'b1;
                        fd[8*b +: 8] = q[i].data[8*b +: 8];
                    end
        check("ld_fwd_en", 32'(ld_fwd_en), 32'(fe));
        check("ld_fwd_data", ld_fwd_data, fd);
        acc = v && rdy && legal && !exc;
        pop = (q.size() != 0) && mr;
        mrg = 1'b0;
        if (acc && COMBINE != 0 && q.size() != 0)
            mrg = (q[q.size()-1].waddr == addr[31:2]) && !(pop && q.size() == 1);
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (mrg) begin
                e = q[q.size()-1];
                for (int b = 0; b < 4; b++)
                    if (be[b]) e.data[8*b +: 8] = d[8*b +: 8];
                e.be = e.be | be;
                q[q.size()-1] = e;
            end
            if (pop) void'(q.pop_front());
            if (acc && !mrg) begin
                e.waddr = addr[31:2]; e.data = d; e.be = be;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input logic mr, input logic rst);
        step(1'b0, 32'h0, 32'h0, OP_NONE, mr, 32'h0, rst);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_op = OP_NONE;
        mem_ready = 1'b0; ld_addr = '0; reset = 1'b1;

        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_byteen", 32'(mem_byteen), 32'h0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_fwd_en", 32'(ld_fwd_en), 32'h0);

        // Alignment of sb and sh onto lanes
        step(1'b1, 32'h103, 32'h12345678, OP_B, 1'b0, 32'h0, 1'b0);
        check("sb_addr", mem_addr, 32'h100);
        check("sb_wdata", mem_wdata, 32'h78000000);
        check("sb_be", 32'(mem_byteen), 32'b1000);
        idle(1'b1, 1'b0);
        step(1'b1, 32'h202, 32'h0000BEEF, OP_H, 1'b0, 32'h0, 1'b0);
        check("sh_wdata", mem_wdata, 32'hBEEF0000);
        check("sh_be", 32'(mem_byteen), 32'b1100);
        idle(1'b1, 1'b0);

        // Three stores merging into one word
        step(1'b1, 32'h40, 32'hAA, OP_B, 1'b0, 32'h40, 1'b0);
        step(1'b1, 32'h41, 32'hBB, OP_B, 1'b0, 32'h40, 1'b0);
        step(1'b1, 32'h42, 32'hCCDD, OP_H, 1'b0, 32'h40, 1'b0);
        check("merge_wdata", mem_wdata, 32'hCCDDBBAA);
        check("merge_be", 32'(mem_byteen), 32'hF);
        idle(1'b1, 1'b0);
        check("merge_single_entry", 32'(empty), 32'd1);

        // Misaligned stores are dropped, a legal sb at the same address is taken
        step(1'b1, 32'h06, 32'h1, OP_W, 1'b0, 32'h0, 1'b0);
        check("sw_mis_no_enq", 32'(empty), 32'd1);
        step(1'b1, 32'h09, 32'h2, OP_H, 1'b0, 32'h0, 1'b0);
        check("sh_mis_no_enq", 32'(empty), 32'd1);
        step(1'b1, 32'h09, 32'h55, OP_B, 1'b0, 32'h0, 1'b0);
        check("sb_odd_enq", 32'(empty), 32'd0);
        check("sb_odd_be", 32'(mem_byteen), 32'b0010);
        idle(1'b1, 1'b0);

        // Fill to DEPTH, hold off a fifth store, then drain in order
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'h1000 + 32'(16 * i), 32'hA0 + 32'(i), OP_W, 1'b0, 32'h0, 1'b0);
        check("full_not_ready", 32'(st_ready), 32'd0);
        step(1'b1, 32'h2000, 32'hDEAD, OP_W, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", mem_addr, 32'h1000 + 32'(16 * i));
            idle(1'b1, 1'b0);
        end
        check("drained_empty", 32'(empty), 32'd1);

        // Push and pop together with one entry: same word must not merge
        step(1'b1, 32'h300, 32'h11111111, OP_W, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h301, 32'h22, OP_B, 1'b1, 32'h0, 1'b0);
        check("pp_new_entry_be", 32'(mem_byteen), 32'b0010);
        check("pp_new_entry_data", mem_wdata, 32'h00002200);
        idle(1'b1, 1'b0);

        // Forwarding from a word and a later byte store
        step(1'b1, 32'h80, 32'h11223344, OP_W, 1'b0, 32'h80, 1'b0);
        step(1'b1, 32'h81, 32'h99, OP_B, 1'b0, 32'h80, 1'b0);
        idle(1'b0, 1'b0);
        ld_addr = 32'h80;
        #1;
        check("fwd_en", 32'(ld_fwd_en), 32'hF);
        check("fwd_data", ld_fwd_data, 32'h11229944);
        ld_addr = 32'h84;
        #1;
        check("fwd_miss_en", 32'(ld_fwd_en), 32'h0);
        idle(1'b1, 1'b0);

        // Reset mid-traffic discards buffered stores
        step(1'b1, 32'h600, 32'h1, OP_W, 1'b0, 32'h600, 1'b0);
        step(1'b1, 32'h604, 32'h2, OP_W, 1'b0, 32'h600, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        check("midrst_mem_valid", 32'(mem_valid), 32'd0);
        check("midrst_byteen", 32'(mem_byteen), 32'h0);
        check("midrst_empty", 32'(empty), 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 1'b0);
            check("midrst_no_write", 32'(mem_valid), 32'd0);
        end

        // Random traffic over a small address pool to exercise merge and forwarding
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 3) != 0),
                 32'h500 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3)),
                 $urandom,
                 3'($urandom_range(0, 3)),
                 1'($urandom_range(0, 2) == 0),
                 32'h500 + 32'($urandom_range(0, 3)) * 4,
                 1'($urandom_range(0, 60) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
